led_bank_arbiter: RTL and testbench
===================================

Name: led_bank_arbiter

Overview:
- Shares the 8-bit board LED bank between NUM_REQ pattern sources: the kit sequencer, a UART debug monitor, a heartbeat and a spare.
- Grants ownership round-robin. A granted source keeps the bank for HOLD_TICKS timebase ticks while others wait.
- Sits between the pattern generators and the LED pins, clocked from the 100 MHz PLL output. i_tick comes from the 1 ms divider, resynchronised to a one-cycle strobe.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, LED pattern width in bits
HOLD_TICKS, 250, i_tick strobes a granted owner keeps the bank while another request is pending (1..65535)
IDLE_PATTERN, 8'h00, LED value driven when there is no owner

Ports:
i_clk  input  1  system clock (CLK100M domain)
i_reset  input  1  asynchronous, active-low reset (0 = reset)
i_tick  input  1  single-cycle timebase strobe
i_req  input  NUM_REQ  per-source request, level; held while the source wants the bank
i_data  input  NUM_REQ*WIDTH  packed patterns; source k occupies bits [k*WIDTH +: WIDTH]
o_grant  output  NUM_REQ  one-hot current owner; all zero when no owner
o_led  output  WIDTH  registered LED drive
o_busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (i_reset low, asynchronous):
  - state = IDLE, o_grant = 0, o_led = IDLE_PATTERN, o_busy = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first. Hold counter = 0.
  - Deassertion is synchronous to i_clk through a 2-flop release.
- States are IDLE, OWN and SWITCH. All outputs are registered.
- IDLE:
  - If any i_req bit is set, choose the first set bit searching from pointer+1 upward with wrap at NUM_REQ-1 -> 0.
  - Next cycle: state = OWN, o_grant = that one-hot, pointer = winner, hold counter = 0.
  - Grant latency is 1 cycle from request.
- OWN:
  - o_led <= i_data slice of the owner every cycle, so o_led lags the owner's data by 1 cycle.
  - The hold counter increments on each i_tick and saturates at HOLD_TICKS.
- OWN exit conditions:
  - Owner's i_req low: next state is SWITCH (release). This takes priority over expiry in the same cycle.
  - Counter == HOLD_TICKS and any other i_req set: next state is SWITCH (preempt).
  - Counter == HOLD_TICKS and no other request: stay in OWN and keep the counter saturated.
  - A new request arriving later then causes SWITCH on the next cycle.
- SWITCH (exactly 1 cycle):
  - o_grant = 0 and o_led = IDLE_PATTERN (a visible blank). o_busy stays 1.
  - Next cycle, run arbitration as in IDLE using the current i_req: go to OWN with the new winner, or to IDLE if i_req == 0.
  - The previous owner is eligible again but has the lowest priority (pointer rule).
- i_tick in IDLE or SWITCH is ignored.
- i_tick coincident with the owner dropping its request: release wins, and the counter is not incremented.
- Widths:
  - Hold counter is ceil(log2(HOLD_TICKS+1)) bits and never wraps.
  - Pointer is ceil(log2(NUM_REQ)) bits.
- Reset asserted mid-OWN: outputs return to reset values immediately (asynchronously). There is no glitch past IDLE_PATTERN.
- i_data of non-owners is never sampled into o_led.
- o_grant is always zero or one-hot, which is a required assertion.

Test Plan:
- Reset then single request:
  - Stimulus: hold i_reset low for 5 cycles and release; raise i_req = 4'b0100 with slice 2 = 8'hA5.
  - Required: o_grant = 4'b0100 one cycle later, o_led = 8'hA5 one cycle after that, o_busy = 1.
- Round-robin fairness:
  - Stimulus: HOLD_TICKS = 2, i_req = 4'b1111 constant, i_tick every 10 cycles.
  - Required: grant order 0,1,2,3,0. Each ownership spans 2 ticks, and each handover has one SWITCH cycle with o_grant = 0 and o_led = 8'h00.
- Voluntary release:
  - Stimulus: owner 1 drops i_req after 3 cycles with none pending.
  - Required: SWITCH for 1 cycle, then IDLE; o_busy = 0, o_led = IDLE_PATTERN.
- Saturated hold without contention:
  - Stimulus: only requester 3 active for 3*HOLD_TICKS ticks; then raise i_req[0].
  - Required: owner 3 is never preempted until i_req[0] rises, then SWITCH on the next cycle and requester 0 is granted.
- Simultaneous release and expiry:
  - Stimulus: owner drops i_req in the same cycle as the HOLD_TICKS-th i_tick while requester 2 is pending.
  - Required: single SWITCH, then grant to 2, with no double switch.
- Asynchronous reset mid-grant:
  - Stimulus: assert i_reset low between clock edges while in OWN.
  - Required: o_grant = 0, o_led = 8'h00, o_busy = 0 before the next edge; the first grant after release goes to requester 0 when all requests are active.

Source files
------------

// File: rtl/led_bank_arbiter_if.sv
// led_bank_arbiter_if: request/pattern inputs and grant/LED outputs of the LED bank arbiter
interface led_bank_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8
);
  logic i_tick;
  logic [NUM_REQ-1:0] i_req;
  logic [NUM_REQ*WIDTH-1:0] i_data;
  logic [NUM_REQ-1:0] o_grant;
  logic [WIDTH-1:0] o_led;
  logic o_busy;
  modport master (output i_tick, i_req, i_data, input o_grant, o_led, o_busy);
  modport slave (input i_tick, i_req, i_data, output o_grant, o_led, o_busy);
endinterface

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: round-robin ownership of the LED bank with tick-based hold and a one-cycle blank on handover
module led_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  parameter int HOLD_TICKS = 250,
  parameter logic [WIDTH-1:0] IDLE_PATTERN = '0
) (
  input logic i_clk,
  input logic i_reset,
  led_bank_arbiter_if.slave bus
);
  localparam int CW = $clog2(HOLD_TICKS + 1);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, OWN, SWITCH} state_t;
  state_t state;
  logic [1:0] rst_sync;
  logic rst_n;
  logic [PW-1:0] ptr, win;
  logic [CW-1:0] cnt;
  logic [NUM_REQ-1:0] grant;
  logic [WIDTH-1:0] led;
  logic busy, found, others, owner_req, expired;
  // reset asserts immediately, releases two clocks after i_reset rises
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];
  // first active requester after the last winner, wrapping, so the last winner ranks lowest
  always_comb begin
    found = 1'b0;
    win = ptr;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && bus.i_req[(int'(ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        win = PW'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end
  assign owner_req = bus.i_req[ptr];
  assign others = |(bus.i_req & ~(NUM_REQ'(1) << ptr));
  assign expired = cnt == CW'(HOLD_TICKS);
  // ownership FSM; ptr doubles as the current owner index while in OWN
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      led <= IDLE_PATTERN;
      busy <= 1'b0;
      ptr <= PW'(NUM_REQ - 1);
      cnt <= '0;
    end else begin
      case (state)
        OWN: begin
          if (!owner_req || (expired && others)) begin
            state <= SWITCH;
            grant <= '0;
            led <= IDLE_PATTERN;
          end else begin
            led <= bus.i_data[int'(ptr)*WIDTH +: WIDTH];
            if (bus.i_tick && !expired) cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (found) begin
            state <= OWN;
            grant <= NUM_REQ'(1) << win;
            ptr <= win;
            cnt <= '0;
            busy <= 1'b1;
          end else begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
      endcase
    end
  end
  assign bus.o_grant = grant;
  assign bus.o_led = led;
  assign bus.o_busy = busy;
  grant_onehot: assert property (@(posedge i_clk) disable iff (!rst_n) $onehot0(grant));
endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb_led_bank_arbiter: random and directed stimulus against an ownership-level model of the arbiter
module tb_led_bank_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  led_bank_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();
  led_bank_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_TICKS(H), .IDLE_PATTERN(8'h00)) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .bus(bus)
  );
  int n_chk = 0;
  int n_fail = 0;
  int m_owner, m_last, m_held;
  bit m_blank;
  logic [W-1:0] m_led;
  logic [N-1:0] prev_grant;
  int gq[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_owner = -1;
    m_last = N - 1;
    m_held = 0;
    m_blank = 0;
    m_led = '0;
  endtask
  function automatic int pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction
  task automatic model_step(input logic [N-1:0] r, input logic t, input logic [N*W-1:0] d);
    int w;
    if (m_owner >= 0) begin
      if (!r[m_owner] || (m_held == H && (r & ~(N'(1) << m_owner)) != 0)) begin
        m_owner = -1;
        m_blank = 1;
        m_led = '0;
      end else begin
        m_led = d[m_owner*W +: W];
        if (t && m_held < H) m_held++;
      end
    end else begin
      w = pick(r);
      m_blank = 0;
      if (w >= 0) begin
        m_owner = w;
        m_last = w;
        m_held = 0;
      end
    end
  endtask
  task automatic cyc(input logic [N-1:0] r, input logic t, input logic [N*W-1:0] d);
    bus.i_req = r;
    bus.i_tick = t;
    bus.i_data = d;
    model_step(r, t, d);
    @(negedge clk);
    check("grant", 32'(bus.o_grant), m_owner >= 0 ? 32'(1) << m_owner : 32'd0);
    check("led", 32'(bus.o_led), 32'(m_led));
    check("busy", 32'(bus.o_busy), 32'(m_owner >= 0 || m_blank));
    check("onehot", 32'($onehot0(bus.o_grant)), 32'd1);
    if (bus.o_grant != 0 && prev_grant == 0) gq.push_back($clog2(bus.o_grant));
    prev_grant = bus.o_grant;
  endtask
  task automatic release_reset();
    rst_n = 1'b1;
    repeat (4) cyc('0, 1'b0, $urandom);
    gq.delete();
  endtask
  task automatic do_reset();
    bus.i_req = '0;
    bus.i_tick = 1'b0;
    rst_n = 1'b0;
    model_reset();
    prev_grant = '0;
    repeat (5) @(negedge clk);
    check("rst_grant", 32'(bus.o_grant), 32'd0);
    check("rst_led", 32'(bus.o_led), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    release_reset();
  endtask
  initial begin
    logic [N-1:0] r;
    bus.i_data = '0;
    do_reset();
    cyc(4'b0100, 1'b0, 32'h00A5_0000);
    check("single_grant", 32'(bus.o_grant), 32'b0100);
    cyc(4'b0100, 1'b0, 32'h00A5_0000);
    check("single_led", 32'(bus.o_led), 32'hA5);
    check("single_busy", 32'(bus.o_busy), 32'd1);
    cyc('0, 1'b0, $urandom);
    cyc('0, 1'b0, $urandom);
    do_reset();
    for (int i = 0; i < 130; i++) cyc(4'hF, i % 10 == 9, $urandom);
    check("rr_count", 32'(gq.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < gq.size(); i++) check("rr_order", 32'(gq[i]), 32'(i % N));
    do_reset();
    repeat (3) cyc(4'b0010, 1'b0, $urandom);
    check("rel_owner", 32'(bus.o_grant), 32'b0010);
    cyc('0, 1'b0, $urandom);
    check("rel_switch_grant", 32'(bus.o_grant), 32'd0);
    check("rel_switch_busy", 32'(bus.o_busy), 32'd1);
    cyc('0, 1'b0, $urandom);
    check("rel_idle_busy", 32'(bus.o_busy), 32'd0);
    check("rel_idle_led", 32'(bus.o_led), 32'd0);
    for (int i = 0; i < 4 * 3 * H; i++) begin
      cyc(4'b1000, i % 4 == 3, $urandom);
      if (i > 0) check("sat_hold", 32'(bus.o_grant), 32'b1000);
    end
    cyc(4'b1001, 1'b0, $urandom);
    check("sat_switch", 32'(bus.o_grant), 32'd0);
    cyc(4'b1001, 1'b0, $urandom);
    check("sat_new_owner", 32'(bus.o_grant), 32'b0001);
    do_reset();
    cyc(4'b0101, 1'b0, $urandom);
    check("sim_owner", 32'(bus.o_grant), 32'b0001);
    cyc(4'b0101, 1'b1, $urandom);
    cyc(4'b0101, 1'b0, $urandom);
    cyc(4'b0100, 1'b1, $urandom);
    check("sim_switch", 32'(bus.o_grant), 32'd0);
    cyc(4'b0100, 1'b0, $urandom);
    check("sim_grant2", 32'(bus.o_grant), 32'b0100);
    repeat (3) begin
      cyc(4'b0100, 1'b1, $urandom);
      check("sim_no_double", 32'(bus.o_grant), 32'b0100);
    end
    do_reset();
    repeat (3) cyc(4'hF, 1'b0, 32'h1122_3344);
    #2 rst_n = 1'b0;
    #1;
    check("async_grant", 32'(bus.o_grant), 32'd0);
    check("async_led", 32'(bus.o_led), 32'd0);
    check("async_busy", 32'(bus.o_busy), 32'd0);
    model_reset();
    prev_grant = '0;
    bus.i_req = '0;
    repeat (2) @(negedge clk);
    release_reset();
    cyc(4'hF, 1'b0, $urandom);
    check("async_first", 32'(bus.o_grant), 32'b0001);
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r = N'($urandom);
      cyc(r, $urandom_range(0, 3) == 0, $urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
